student_tlul_host_arb: RTL and testbench

STUDENT_TLUL_HOST_ARB -- requirements
Module: student_tlul_host_arb

---
 rtl/student_tlul_arb_pkg.sv | 19 +
 rtl/tlul_pkg.sv | 40 ++++
 rtl/student_arb_fifo.sv | 49 ++++
 rtl/student_tlul_host_arb.sv | 96 +++++++++
 tb/tb_student_tlul_host_arb.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/student_tlul_arb_pkg.sv
// Host identifiers and arbiter state types for the two-host TL-UL arbiter.
`timescale 1ns/1ps
package student_tlul_arb_pkg;

  typedef logic host_id_t;

  localparam host_id_t HostCpu = 1'b0;
  localparam host_id_t HostDma = 1'b1;

  typedef enum logic {
    LockIdle,
    LockHeld
  } lock_state_e;

  function automatic host_id_t other_host(input host_id_t h);
    return ~h;
  endfunction

endpackage

// File: rtl/tlul_pkg.sv
// Minimal TL-UL channel definitions shared by hosts, arbiter and device port.
`timescale 1ns/1ps
package tlul_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/student_arb_fifo.sv
// Small synchronous FIFO tracking which host owns each outstanding A beat.
`timescale 1ns/1ps
module student_arb_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] FullCnt = (PtrW+1)'(Depth);

  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [PtrW:0]   count_q;
  logic [Width-1:0] mem_q [Depth];
  logic push_ok, pop_ok;

  assign full_o  = (count_q == FullCnt);
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];

  // Pointers are exactly log2(Depth) bits, so wrap-around is free.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + PtrW'(1);
      if (pop_ok)  rptr_q <= rptr_q + PtrW'(1);
      if (push_ok && !pop_ok)      count_q <= count_q + (PtrW+1)'(1);
      else if (pop_ok && !push_ok) count_q <= count_q - (PtrW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/student_tlul_host_arb.sv
// Two-host TL-UL arbiter: round-robin A-channel merge with grant lock,
// D-channel return steered by an in-order outstanding-host queue.
`timescale 1ns/1ps
module student_tlul_host_arb
  import student_tlul_arb_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  tlul_pkg::tl_h2d_t tl_h0_i,
  output tlul_pkg::tl_d2h_t tl_h0_o,
  input  tlul_pkg::tl_h2d_t tl_h1_i,
  output tlul_pkg::tl_d2h_t tl_h1_o,
  output tlul_pkg::tl_h2d_t tl_dev_o,
  input  tlul_pkg::tl_d2h_t tl_dev_i,
  output logic              orphan_o
);

  lock_state_e lock_q;
  host_id_t    lock_host_q, last_gnt_q, gnt, head;
  logic [1:0]  req;
  logic        lock_active, gnt_valid, fifo_full, fifo_empty;
  logic        dev_a_valid, host_a_ready, a_hs, head_d_ready, dev_d_ready, d_hs;
  tlul_pkg::tl_h2d_t sel_req;
  tlul_pkg::tl_d2h_t d_rsp;

  assign req = {tl_h1_i.a_valid, tl_h0_i.a_valid};

  // A locked host that has gone idle releases the grant in the same cycle.
  always_comb begin
    lock_active = (lock_q == LockHeld) && req[lock_host_q];
    if (lock_active)   gnt = lock_host_q;
    else if (&req)     gnt = other_host(last_gnt_q);
    else if (req[HostDma]) gnt = HostDma;
    else               gnt = HostCpu;
    gnt_valid    = req[gnt];
    sel_req      = (gnt == HostDma) ? tl_h1_i : tl_h0_i;
    dev_a_valid  = rst_ni && gnt_valid && !fifo_full;
    host_a_ready = dev_a_valid && tl_dev_i.a_ready;
    a_hs         = host_a_ready;
    head_d_ready = (head == HostDma) ? tl_h1_i.d_ready : tl_h0_i.d_ready;
    dev_d_ready  = rst_ni && (fifo_empty || head_d_ready);
    d_hs         = tl_dev_i.d_valid && dev_d_ready && !fifo_empty;
  end

  assign orphan_o = rst_ni && fifo_empty && tl_dev_i.d_valid;

  always_comb begin
    tl_dev_o         = sel_req;
    tl_dev_o.a_valid = dev_a_valid;
    tl_dev_o.d_ready = dev_d_ready;
    d_rsp            = tl_dev_i;
    d_rsp.a_ready    = 1'b0;
    d_rsp.d_valid    = rst_ni && !fifo_empty && tl_dev_i.d_valid;
    tl_h0_o = '0;
    tl_h1_o = '0;
    if (!fifo_empty) begin
      if (head == HostDma) tl_h1_o = d_rsp;
      else                 tl_h0_o = d_rsp;
    end
    tl_h0_o.a_ready = host_a_ready && (gnt == HostCpu);
    tl_h1_o.a_ready = host_a_ready && (gnt == HostDma);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q      <= LockIdle;
      lock_host_q <= HostCpu;
      last_gnt_q  <= HostDma;
    end else if (a_hs) begin
      lock_q     <= LockIdle;
      last_gnt_q <= gnt;
    end else if (gnt_valid) begin
      lock_q      <= LockHeld;
      lock_host_q <= gnt;
    end else begin
      lock_q <= LockIdle;
    end
  end

  student_arb_fifo #(
    .Depth(MaxOutstanding),
    .Width(1)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (a_hs),
    .wdata_i (gnt),
    .pop_i   (d_hs),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_student_tlul_host_arb.sv
// Self-checking bench for student_tlul_host_arb: vector table plus directed sequences.
`timescale 1ns/1ps
module tb_student_tlul_host_arb;

  logic clk = 1'b0;
  logic rst_ni;
  tlul_pkg::tl_h2d_t h0, h1, dev_req;
  tlul_pkg::tl_d2h_t h0_rsp, h1_rsp, dev_rsp;
  logic orphan;

  int total = 0;
  int bad = 0;
  logic [15:0] seq_tag = '0;
  bit sb[$];

  always #5 clk = ~clk;

  student_tlul_host_arb #(.MaxOutstanding(4)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_ni),
    .tl_h0_i  (h0),
    .tl_h0_o  (h0_rsp),
    .tl_h1_i  (h1),
    .tl_h1_o  (h1_rsp),
    .tl_dev_o (dev_req),
    .tl_dev_i (dev_rsp),
    .orphan_o (orphan)
  );

  typedef struct {
    bit v0, v1, ar, dv;
    bit e_av, e_g, e_r0, e_r1;
  } vec_t;

  vec_t vecs[13];

  task automatic chk_b(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    end
  endtask

  task automatic chk_w(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit v0, input bit v1, input bit ar, input bit dv);
    seq_tag++;
    h0 = '0;
    h0.a_valid   = v0;
    h0.a_opcode  = tlul_pkg::Get;
    h0.a_address = 32'h1000_0000 | {16'h0, seq_tag};
    h0.d_ready   = 1'b1;
    h1 = '0;
    h1.a_valid   = v1;
    h1.a_opcode  = tlul_pkg::PutFullData;
    h1.a_address = 32'h2000_0000 | {16'h0, seq_tag};
    h1.a_data    = {16'h0, seq_tag};
    h1.a_mask    = 4'hf;
    h1.d_ready   = 1'b1;
    dev_rsp = '0;
    dev_rsp.a_ready  = ar;
    dev_rsp.d_valid  = dv;
    dev_rsp.d_opcode = tlul_pkg::AccessAck;
    dev_rsp.d_data   = 32'hD000_0000 | {16'h0, seq_tag};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // D side: the scoreboard head names the host that must see the response.
  task automatic check_d(input string nm);
    bit routed = 1'b0;
    bit h = 1'b0;
    if (dev_rsp.d_valid && sb.size() > 0) begin
      h = sb.pop_front();
      routed = 1'b1;
    end
    chk_b({nm, ".h0_d_valid"}, h0_rsp.d_valid, routed && !h);
    chk_b({nm, ".h1_d_valid"}, h1_rsp.d_valid, routed && h);
    chk_b({nm, ".orphan"}, orphan, dev_rsp.d_valid && !routed);
    chk_b({nm, ".dev_d_ready"}, dev_req.d_ready, 1'b1);
    if (routed)
      chk_w({nm, ".d_data"}, h ? h1_rsp.d_data : h0_rsp.d_data, dev_rsp.d_data);
  endtask

  task automatic check_a(input string nm, input bit e_av, input bit e_g,
                         input bit e_r0, input bit e_r1);
    chk_b({nm, ".dev_a_valid"}, dev_req.a_valid, e_av);
    chk_b({nm, ".h0_a_ready"}, h0_rsp.a_ready, e_r0);
    chk_b({nm, ".h1_a_ready"}, h1_rsp.a_ready, e_r1);
    if (e_av) begin
      chk_w({nm, ".a_addr_host"}, {28'h0, dev_req.a_address[31:28]}, e_g ? 32'h2 : 32'h1);
      chk_w({nm, ".a_addr_tag"}, {16'h0, dev_req.a_address[15:0]}, {16'h0, seq_tag});
    end
    if (e_av && dev_rsp.a_ready) sb.push_back(e_g);
  endtask

  task automatic cyc(input string nm, input bit v0, input bit v1, input bit ar, input bit dv,
                     input bit e_av, input bit e_g, input bit e_r0, input bit e_r1);
    drive(v0, v1, ar, dv);
    #4;
    check_d(nm);
    check_a(nm, e_av, e_g, e_r0, e_r1);
    step();
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    #2;
    chk_b("rst.dev_a_valid", dev_req.a_valid, 1'b0);
    chk_b("rst.dev_d_ready", dev_req.d_ready, 1'b0);
    chk_b("rst.h0_a_ready", h0_rsp.a_ready, 1'b0);
    chk_b("rst.h1_a_ready", h1_rsp.a_ready, 1'b0);
    chk_b("rst.h0_d_valid", h0_rsp.d_valid, 1'b0);
    chk_b("rst.h1_d_valid", h1_rsp.d_valid, 1'b0);
    chk_b("rst.orphan", orphan, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    sb.delete();
  endtask

  task automatic drain(input string nm);
    int guard = 0;
    while (sb.size() > 0 && guard < 16) begin
      cyc(nm, 0, 0, 0, 1, 0, 0, 0, 0);
      guard++;
    end
    chk_w({nm, ".left"}, 32'(sb.size()), 32'h0);
  endtask

  initial begin
    // {v0, v1, a_ready, d_valid, exp a_valid, exp grant, exp h0 a_ready, exp h1 a_ready}
    vecs[0]  = '{0, 0, 1, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 1, 1, 0, 1, 0, 1, 0};
    vecs[2]  = '{1, 1, 1, 0, 1, 1, 0, 1};
    vecs[3]  = '{1, 0, 0, 1, 1, 0, 0, 0};
    vecs[4]  = '{1, 1, 0, 0, 1, 0, 0, 0};
    vecs[5]  = '{1, 1, 1, 1, 1, 0, 1, 0};
    vecs[6]  = '{1, 1, 1, 1, 1, 1, 0, 1};
    vecs[7]  = '{0, 0, 1, 1, 0, 0, 0, 0};
    vecs[8]  = '{0, 0, 1, 1, 0, 0, 0, 0};
    vecs[9]  = '{0, 1, 1, 0, 1, 1, 0, 1};
    vecs[10] = '{1, 1, 1, 0, 1, 0, 1, 0};
    vecs[11] = '{0, 0, 0, 1, 0, 0, 0, 0};
    vecs[12] = '{0, 0, 0, 1, 0, 0, 0, 0};

    rst_ni = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    do_reset();

    for (int i = 0; i < 13; i++) begin
      cyc($sformatf("vec%0d", i), vecs[i].v0, vecs[i].v1, vecs[i].ar, vecs[i].dv,
          vecs[i].e_av, vecs[i].e_g, vecs[i].e_r0, vecs[i].e_r1);
    end
    chk_w("vec.sb_empty", 32'(sb.size()), 32'h0);

    // Grant held by host 1 across a stalled device; a tie here would otherwise go to host 0.
    do_reset();
    cyc("lock0", 0, 1, 0, 0, 1, 1, 0, 0);
    cyc("lock1", 1, 1, 0, 0, 1, 1, 0, 0);
    cyc("lock2", 1, 1, 0, 0, 1, 1, 0, 0);
    cyc("lock3", 1, 1, 1, 0, 1, 1, 0, 1);
    cyc("lock4", 1, 0, 1, 0, 1, 0, 1, 0);
    drain("lock_drain");

    // Fill the tracker, stay blocked through a same-cycle pop, resume next cycle.
    do_reset();
    for (int i = 0; i < 4; i++) cyc($sformatf("fill%0d", i), 0, 1, 1, 0, 1, 1, 0, 1);
    cyc("full0", 1, 1, 1, 0, 0, 0, 0, 0);
    cyc("full1", 1, 1, 1, 0, 0, 0, 0, 0);
    cyc("full_pop", 1, 1, 1, 1, 0, 0, 0, 0);
    cyc("resume", 0, 1, 1, 0, 1, 1, 0, 1);
    drain("full_drain");

    // Push and pop together at occupancy 2: two more fit, then blocked; head moved to host 1.
    do_reset();
    cyc("pp0", 1, 0, 1, 0, 1, 0, 1, 0);
    cyc("pp1", 0, 1, 1, 0, 1, 1, 0, 1);
    cyc("pp_both", 1, 0, 1, 1, 1, 0, 1, 0);
    cyc("pp3", 0, 1, 1, 0, 1, 1, 0, 1);
    cyc("pp4", 0, 1, 1, 0, 1, 1, 0, 1);
    cyc("pp_full", 0, 1, 1, 0, 0, 0, 0, 0);
    drain("pp_drain");

    // Reset with three outstanding: late response is an orphan, routed nowhere.
    do_reset();
    cyc("mr0", 1, 0, 1, 0, 1, 0, 1, 0);
    cyc("mr1", 0, 1, 1, 0, 1, 1, 0, 1);
    cyc("mr2", 1, 0, 1, 0, 1, 0, 1, 0);
    do_reset();
    cyc("late_d", 0, 0, 0, 1, 0, 0, 0, 0);
    cyc("late_idle", 0, 0, 0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
